control_ventilacion: RTL
========================

Name: control_ventilacion

Overview:
Downstream consumer of the keyboard-command decode path. Takes the 4-bit temperature code from the temperature decoder and the Gas/Alerta/Peligro/RESETFSM flags from the command interpreter. Drives a fan PWM output, an alert LED and a buzzer through a 4-state supervisory FSM, with hysteresis on alert exit and a sticky danger state.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
PWM_HZ, 25000, PWM frame rate. Prescaler PRESC = CLK_HZ/(PWM_HZ*256), clamped to a minimum of 1.
BLINK_HZ, 2, blink rate for the LED and buzzer.
HOLD_PERIODS, 64, number of consecutive PWM frames with Alerta=Gas=0 required to leave ALERTA.
RAMP_STEP, 16, maximum duty change per PWM frame (used only with SOFT_START_EN).

Ports:
CLK  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
Temps  in  4  temperature code, 0..15.
Gas  in  1  gas-detected level.
Alerta  in  1  alert level.
Peligro  in  1  danger level.
RESETFSM  in  1  synchronous soft clear from the command interpreter.
pwm_fan  out  1  fan PWM.
duty  out  8  currently applied duty.
led_alerta  out  1  alert LED.
buzzer  out  1  buzzer enable.
estado  out  2  FSM state: 00 APAGADO, 01 NORMAL, 10 ALERTA, 11 PELIGRO.

Behaviour:
- Reset (reset=0): all outputs 0, estado=00, all counters 0. Takes effect immediately with no clock edge; pwm_fan drops mid-frame.
- Inputs are registered once. A state change is visible on estado 2 CLK edges after the input changes.
- Prescaler counts 0..PRESC-1 and pulses tick at its terminal count. pwm_cnt is 8 bits, increments on tick, wraps 255->0. The wrap is the frame boundary.
- pwm_fan = (pwm_cnt < duty), except duty=255 forces constant 1. duty=0 gives constant 0.
- Target duty by state:
  - APAGADO: 0.
  - NORMAL: Temps<<4, range 0..240.
  - ALERTA: max(Temps<<4, 192).
  - PELIGRO: 255.
- Applied duty loads the target only at a frame boundary, so frames never glitch. Exceptions: entry into APAGADO or PELIGRO loads immediately, on the same edge as the state change.
- FSM transitions, evaluated on registered inputs, priority top-down:
  - RESETFSM=1: any state -> APAGADO.
  - APAGADO, RESETFSM=0: Peligro -> PELIGRO; else Alerta|Gas -> ALERTA; else -> NORMAL.
  - NORMAL: Peligro -> PELIGRO; Alerta|Gas -> ALERTA.
  - ALERTA: Peligro -> PELIGRO. A hold counter counts frames with Alerta=Gas=0 and clears on any reassertion. Reaching HOLD_PERIODS -> NORMAL.
  - PELIGRO: sticky. It is left only via RESETFSM.
- RESETFSM and Peligro in the same cycle -> APAGADO. If Peligro is still high on the next cycle -> PELIGRO.
- Blink: a counter toggles the blink bit every CLK_HZ/(2*BLINK_HZ) cycles. It free-runs from reset.
- led_alerta: 0 in APAGADO/NORMAL, blink in ALERTA, 1 in PELIGRO.
- buzzer: blink in PELIGRO, else 0.
- Temps changes mid-frame take effect at the next frame boundary only.

Optional Feature:
SOFT_START_EN:
- When defined, at each frame boundary the applied duty moves toward the target by at most RAMP_STEP, in both directions, saturating exactly at the target.
- APAGADO (0) and PELIGRO (255) still load immediately.
- When undefined, the applied duty equals the target at the next frame boundary. RAMP_STEP is then unused.

Decomposition:
- Package control_ventilacion_pkg holds:
  - state encodings APAGADO/NORMAL/ALERTA/PELIGRO;
  - DUTY_MAX=255 and ALERTA_MIN_DUTY=192;
  - TEMP_SHIFT=4.
- Sub-module generador_pwm contains the prescaler, pwm_cnt, the comparator with the duty=255 override, and the frame-boundary pulse output.
- The FSM, hold counter, blink logic and duty selection/ramp stay in the top level.

Test Plan:
All scenarios use CLK_HZ=25600 and PWM_HZ=100, giving PRESC=1; soft start is off unless stated.
- Release reset with RESETFSM=0, Temps=5 -> estado=01 within 2 cycles; duty=80 after the first wrap; pwm_fan high for 80 of every 256 cycles.
- Temps=3, Alerta high 1 cycle -> estado=10; duty=192 at the next boundary; led_alerta blinks. With HOLD_PERIODS=4, after 4 clean frames -> estado=01 and duty=48. Re-pulsing Gas at frame 3 restarts the hold count.
- Peligro high 1 cycle -> estado=11; duty=255 on the same edge; pwm_fan constant 1; buzzer toggles. After Peligro drops, estado stays 11. RESETFSM for 1 cycle -> estado=00 and duty=0.
- RESETFSM=1 and Peligro=1 in the same cycle -> estado=00. On the next cycle, with Peligro=1 and RESETFSM=0 -> estado=11.
- duty=128 with pwm_fan=1, assert reset asynchronously between edges -> pwm_fan=0 and duty=0 immediately.
- SOFT_START_EN with RAMP_STEP=16, NORMAL, Temps 0->15 -> duty 16, 32, …, 240 over 15 frames. Then Temps 15->0 -> duty ramps down by 16 per frame to 0.

Source files
------------

// File: rtl/control_ventilacion_pkg.sv
// Shared types and constants for the ventilation supervisor: state encoding,
// duty limits and the state/temperature -> target duty mapping.
package control_ventilacion_pkg;

  typedef enum logic [1:0] {
    APAGADO = 2'b00,
    NORMAL  = 2'b01,
    ALERTA  = 2'b10,
    PELIGRO = 2'b11
  } estado_t;

  localparam logic [7:0] DUTY_MAX        = 8'd255;
  localparam logic [7:0] ALERTA_MIN_DUTY = 8'd192;
  localparam int         TEMP_SHIFT      = 4;

  function automatic logic [7:0] target_duty(estado_t s, logic [3:0] t);
    logic [7:0] scaled;
    scaled = 8'(t) << TEMP_SHIFT;
    case (s)
      APAGADO: return 8'd0;
      NORMAL:  return scaled;
      ALERTA:  return (scaled > ALERTA_MIN_DUTY) ? scaled : ALERTA_MIN_DUTY;
      default: return DUTY_MAX;
    endcase
  endfunction

endpackage

// File: rtl/control_ventilacion_pwm.sv
// PWM generator: prescaler, 8-bit frame counter, comparator with full-on
// override at DUTY_MAX, and a one-cycle pulse on the 255->0 frame wrap.
module generador_pwm
  import control_ventilacion_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int PWM_HZ = 25_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic       frame
);

  localparam int PRESC_RAW = CLK_HZ / (PWM_HZ * 256);
  localparam int PRESC     = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int PW        = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;

  assign tick = (presc_cnt == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign frame   = tick && (pwm_cnt == 8'hFF);
  // Combinational so an asynchronous reset drops the output mid-frame.
  assign pwm_out = (duty == DUTY_MAX) || (pwm_cnt < duty);

endmodule

// File: rtl/control_ventilacion.sv
// Ventilation supervisor: 4-state FSM driving fan duty, alert LED and buzzer.
// Define SOFT_START_EN to ramp the duty toward its target by RAMP_STEP per frame.
module control_ventilacion
  import control_ventilacion_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int PWM_HZ       = 25_000,
  parameter int BLINK_HZ     = 2,
  parameter int HOLD_PERIODS = 64,
  parameter int RAMP_STEP    = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] Temps,
  input  logic       Gas,
  input  logic       Alerta,
  input  logic       Peligro,
  input  logic       RESETFSM,
  output logic       pwm_fan,
  output logic [7:0] duty,
  output logic       led_alerta,
  output logic       buzzer,
  output logic [1:0] estado
);

`ifdef SOFT_START_EN
  localparam bit SOFT_START = 1'b1;
`else
  localparam bit SOFT_START = 1'b0;
`endif
  // Without soft start the step exceeds any possible difference, so the target loads directly.
  localparam int DUTY_STEP  = SOFT_START ? RAMP_STEP : 256;
  localparam int BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int HOLD_W     = $clog2(HOLD_PERIODS + 1);

  logic [3:0]         temps_r;
  logic               gas_r, alerta_r, peligro_r, rstfsm_r;
  estado_t            state, state_next;
  logic [7:0]         duty_q, duty_next, duty_tgt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_q, frame, hold_done;
  int                 diff;

  generador_pwm #(.CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ)) u_pwm (
    .clk     (CLK),
    .rst_n   (reset),
    .duty    (duty_q),
    .pwm_out (pwm_fan),
    .frame   (frame)
  );

  assign hold_done = frame && !alerta_r && !gas_r &&
                     (hold_cnt == HOLD_W'(HOLD_PERIODS - 1));

  always_comb begin
    state_next = state;
    if (rstfsm_r) begin
      state_next = APAGADO;
    end else begin
      case (state)
        APAGADO: begin
          if (peligro_r)              state_next = PELIGRO;
          else if (alerta_r || gas_r) state_next = ALERTA;
          else                        state_next = NORMAL;
        end
        NORMAL: begin
          if (peligro_r)              state_next = PELIGRO;
          else if (alerta_r || gas_r) state_next = ALERTA;
        end
        ALERTA: begin
          if (peligro_r)      state_next = PELIGRO;
          else if (hold_done) state_next = NORMAL;
        end
        PELIGRO: state_next = PELIGRO;
        default: state_next = APAGADO;
      endcase
    end
  end

  // Duty follows the upcoming state so an exit from ALERTA lands on the new target at once.
  always_comb begin
    duty_tgt  = target_duty(state_next, temps_r);
    diff      = int'(duty_tgt) - int'(duty_q);
    duty_next = duty_q;
    if ((state_next != state) && (state_next == APAGADO || state_next == PELIGRO)) begin
      duty_next = duty_tgt;
    end else if (frame) begin
      if (diff > DUTY_STEP)       duty_next = duty_q + 8'(DUTY_STEP);
      else if (diff < -DUTY_STEP) duty_next = duty_q - 8'(DUTY_STEP);
      else                        duty_next = duty_tgt;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      temps_r   <= '0;
      gas_r     <= 1'b0;
      alerta_r  <= 1'b0;
      peligro_r <= 1'b0;
      rstfsm_r  <= 1'b0;
      state     <= APAGADO;
      duty_q    <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      temps_r   <= Temps;
      gas_r     <= Gas;
      alerta_r  <= Alerta;
      peligro_r <= Peligro;
      rstfsm_r  <= RESETFSM;
      state     <= state_next;
      duty_q    <= duty_next;
      if (state != ALERTA || state_next != ALERTA || alerta_r || gas_r) hold_cnt <= '0;
      else if (frame) hold_cnt <= hold_cnt + 1'b1;
      if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign duty       = duty_q;
  assign estado     = state;
  assign led_alerta = (state == PELIGRO) || ((state == ALERTA) && blink_q);
  assign buzzer     = (state == PELIGRO) && blink_q;

endmodule
